// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - sequential 6-iteration successive-approximation CORDIC-style angle search
//
// Purpose:
//   Each accepted start latches a 6-bit target angle code and walks an accumulator toward it
//   with binary-weighted steps (32,16,8,4,2,1), recording one direction decision per iteration.
//
// Ports:
//   CLK     in   1  system clock, rising edge
//   RST     in   1  synchronous active-high reset, overrides start
//   start   in   1  request pulse, accepted in IDLE or DONE
//   z       in   6  target angle code, sampled on accepted start
//   busy    out  1  high while in RUN
//   done    out  1  high for the single DONE cycle
//   result  out  6  direction vector, bit 5 = iteration 0 decision
//   approx  out  6  final accumulated angle
//   iter    out  3  current iteration index 0..5
//
// Configuration:
//   CORDIC_EARLY_EXIT_EN  when defined, RUN ends as soon as acc equals target at the start of
//                         a cycle; result/approx are unchanged, only latency shrinks.

module cordic_seq (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [5:0] z,
    output logic       busy,
    output logic       done,
    output logic [5:0] result,
    output logic [5:0] approx,
    output logic [2:0] iter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] target_q, target_d;
    logic [6:0] acc_q, acc_d;
    logic [5:0] result_q, result_d;
    logic [2:0] iter_q, iter_d;

    logic       accept;
    logic       acc_eq;
    logic       acc_lt;
    logic       early_exit;
    logic [6:0] step;
    logic [5:0] bit_mask;

    // A start is only honoured outside RUN; a start during RUN has no effect at all.
    assign accept = start && (state_q != S_RUN);
    assign acc_eq = (acc_q == {1'b0, target_q});
    assign acc_lt = (acc_q <  {1'b0, target_q});

`ifdef CORDIC_EARLY_EXIT_EN
    assign early_exit = acc_eq;
`else
    assign early_exit = 1'b0;
`endif

    // Binary-weighted step table indexed by the iteration counter.
    always_comb begin
        step = 7'd0;
        case (iter_q)
            3'd0:    step = 7'd32;
            3'd1:    step = 7'd16;
            3'd2:    step = 7'd8;
            3'd3:    step = 7'd4;
            3'd4:    step = 7'd2;
            3'd5:    step = 7'd1;
            default: step = 7'd0;
        endcase
    end

    // Iteration i owns result bit (5-i).
    assign bit_mask = 6'b100000 >> iter_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (early_exit || (iter_q == 3'd5)) state_d = S_DONE;
            S_DONE: state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        target_d = target_q;
        acc_d    = acc_q;
        result_d = result_q;
        iter_d   = iter_q;
        if (accept) begin
            target_d = z;
            acc_d    = 7'd0;
            result_d = 6'd0;
            iter_d   = 3'd0;
        end else if (state_q == S_RUN && !early_exit) begin
            if (acc_lt) begin
                acc_d    = acc_q + step;
                result_d = result_q | bit_mask;
            end else if (!acc_eq) begin
                acc_d    = acc_q - step;
                result_d = result_q & ~bit_mask;
            end else begin
                result_d = result_q & ~bit_mask;
            end
            // Saturate at the last index so iter reads 5 after a full run.
            iter_d = (iter_q == 3'd5) ? 3'd5 : iter_q + 3'd1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            target_q <= 6'd0;
            acc_q    <= 7'd0;
            result_q <= 6'd0;
            iter_q   <= 3'd0;
        end else begin
            target_q <= target_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            iter_q   <= iter_d;
        end
    end

    // The 6-bit target bounds acc to 0..63, so the low six bits are the full value.
    assign result = result_q;
    assign approx = acc_q[5:0];
    assign iter   = iter_q;

endmodule

// File: tb/tb_cordic_seq.sv
// tb/tb_cordic_seq.sv - self-checking bench for cordic_seq against a behavioural search model

module tb_cordic_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [5:0] z;
    logic       busy;
    logic       done;
    logic [5:0] result;
    logic [5:0] approx;
    logic [2:0] iter;

    int errors = 0;
    int checks = 0;

`ifdef CORDIC_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    cordic_seq dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .z      (z),
        .busy   (busy),
        .done   (done),
        .result (result),
        .approx (approx),
        .iter   (iter)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Binary search toward t with halving steps; runs = RUN cycles spent, it = final iter.
    function automatic void model(input logic [5:0] t, output logic [5:0] res,
                                  output logic [5:0] apx, output int runs, output int it);
        int  a;
        bit  stop;
        a    = 0;
        stop = 0;
        res  = '0;
        runs = 6;
        it   = 5;
        for (int i = 0; i < 6; i++) begin
            if (!stop) begin
                if (EE && a == int'(t)) begin
                    runs = i + 1;
                    it   = i;
                    stop = 1;
                end else if (a < int'(t)) begin
                    a = a + (32 >> i);
                    res[5-i] = 1'b1;
                end else if (a > int'(t)) begin
                    a = a - (32 >> i);
                end
            end
        end
        apx = a[5:0];
    endfunction

    // Accept an operation (from IDLE or DONE), wait for done, compare everything.
    // mid_start_at > 0 injects a start pulse with z=5 after that many RUN ticks.
    task automatic run_op(input logic [5:0] zv, input string tag, input int mid_start_at);
        logic [5:0] e_res, e_apx;
        int         e_runs, e_it, cnt;
        model(zv, e_res, e_apx, e_runs, e_it);
        start = 1'b1;
        z     = zv;
        tick();
        start = 1'b0;
        z     = 6'($urandom);
        check({tag, "_busy"}, busy, 1);
        cnt = 0;
        while (!done && cnt < 20) begin
            if (mid_start_at > 0 && cnt == mid_start_at) begin
                start = 1'b1;
                z     = 6'd5;
            end
            tick();
            start = 1'b0;
            cnt++;
        end
        check({tag, "_latency"}, cnt, e_runs);
        check({tag, "_result"}, result, e_res);
        check({tag, "_approx"}, approx, e_apx);
        check({tag, "_iter"}, iter, e_it);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        logic [5:0] rz;
        RST   = 1'b1;
        start = 1'b0;
        z     = 6'd0;
        tick();
        start = 1'b1;
        z     = 6'd33;
        tick();
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_approx", approx, 0);
        check("rst_iter", iter, 0);
        RST = 1'b0;
        tick();

        run_op(6'd20, "z20", 0);
        check("z20_res_const", result, 6'b101000);
        check("z20_apx_const", approx, 20);
        run_op(6'd63, "z63", 0);
        check("z63_res_const", result, 6'b111111);
        run_op(6'd1, "z1", 0);
        check("z1_res_const", result, 6'b100000);
        run_op(6'd0, "z0", 0);
        check("z0_res_const", result, 0);

        // DONE falls back to IDLE and outputs are held there.
        tick();
        check("hold_done", done, 0);
        tick();
        check("hold_result", result, 0);
        check("hold_approx", approx, 0);

        run_op(6'd40, "z40_ign", 2);
        check("z40_res_const", result, 6'b110000);
        check("z40_apx_const", approx, 40);
        tick();
        tick();
        check("hold40_result", result, 6'b110000);
        check("hold40_approx", approx, 40);

        // Reset in RUN cycle 3 of z=45, with start asserted alongside.
        start = 1'b1;
        z     = 6'd45;
        tick();
        start = 1'b0;
        tick();
        tick();
        RST   = 1'b1;
        start = 1'b1;
        z     = 6'd7;
        tick();
        RST   = 1'b0;
        start = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_result", result, 0);
        check("mrst_approx", approx, 0);
        check("mrst_iter", iter, 0);
        tick();
        check("mrst_idle", busy, 0);
        run_op(6'd45, "z45", 0);
        check("z45_apx_const", approx, 45);

        for (int k = 0; k < 24; k++) begin
            rz = 6'($urandom);
            run_op(rz, "rand", 0);
            if (($urandom & 1) != 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
